// File: rtl/vram_scroll.sv
// -----------------------------------------------------------------------------
// vram_scroll
// Scroll engine for the text-mode VRAM. On a start pulse it moves the whole
// character grid up or down by a programmable number of lines, and writes a
// programmable fill character into the rows that are left empty.
//
// Ports
//   i_clk, i_rst_n   clock; asynchronous active-low reset
//   i_start          start request, sampled only while idle
//   i_dir            0 = scroll up (toward row 0), 1 = scroll down
//   i_lines          number of lines to scroll
//   i_fill           character written into the vacated rows
//   o_busy, o_done   busy level and one-cycle completion pulse
//   o_vram_*         VRAM port: {row,col} address, write data, ce, wre
//   i_vram_dout      VRAM read data, valid one cycle after a read address
// -----------------------------------------------------------------------------
module vram_scroll #(
  parameter int ROW_W    = 5,
  parameter int COL_W    = 6,
  parameter int LAST_ROW = 16,
  parameter int LAST_COL = 59,
  parameter int DATA_W   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_dir,
  input  logic [ROW_W-1:0]       i_lines,
  input  logic [DATA_W-1:0]      i_fill,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ROW_W+COL_W-1:0] o_vram_addr,
  output logic [DATA_W-1:0]      o_vram_din,
  input  logic [DATA_W-1:0]      i_vram_dout,
  output logic                   o_vram_ce,
  output logic                   o_vram_wre
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(LAST_ROW);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(LAST_COL);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  typedef struct packed {
    logic             fill;  // destination gets the fill character
    logic [ROW_W-1:0] src;   // source row, meaningful only when !fill
  } cell_t;

  // Classify a destination row. The up-mode sum needs one extra bit so that a
  // large line count cannot wrap back into the visible range.
  function automatic cell_t classify(input logic             dir,
                                     input logic [ROW_W-1:0] lines,
                                     input logic [ROW_W-1:0] row);
    logic [ROW_W:0] sum;
    cell_t          c;
    sum = {1'b0, row} + {1'b0, lines};
    if (!dir) begin
      c.fill = (sum > {1'b0, ROW_MAX});
      c.src  = sum[ROW_W-1:0];
    end else begin
      c.fill = (row < lines);
      c.src  = row - lines;
    end
    return c;
  endfunction

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic                    dir_q;
  logic [ROW_W-1:0]        lines_q;
  logic [DATA_W-1:0]       fill_q;
  logic [ROW_W+COL_W-1:0]  addr_hold_q;
  logic [DATA_W-1:0]       din_hold_q;

  cell_t                   cur, nxt;
  logic                    last_row;
  logic [ROW_W+COL_W-1:0]  vram_addr;
  logic [DATA_W-1:0]       vram_din;

  assign cur = classify(dir_q, lines_q, row_q);

  // Next-state and position sequencing.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    nxt      = '0;
    last_row = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          row_d = i_dir ? ROW_MAX : '0;
          col_d = '0;
          nxt   = classify(i_dir, i_lines, row_d);
          if (i_lines == '0)  state_d = S_DONE;
          else if (nxt.fill)  state_d = S_WRITE;
          else                state_d = S_READ;
        end
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        last_row = dir_q ? (row_q == '0) : (row_q == ROW_MAX);
        if (col_q == COL_MAX) begin
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            col_d = '0;
            row_d = dir_q ? row_q - ROW_W'(1) : row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
        if (state_d != S_DONE) begin
          nxt     = classify(dir_q, lines_q, row_d);
          state_d = nxt.fill ? S_WRITE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // VRAM address/data. A copy write forwards the read data straight through,
  // because it only becomes valid in the write cycle itself. Outside an access
  // the last driven values are held.
  always_comb begin
    vram_addr = addr_hold_q;
    vram_din  = din_hold_q;
    case (state_q)
      S_READ:  vram_addr = {cur.src, col_q};
      S_WRITE: begin
        vram_addr = {row_q, col_q};
        vram_din  = cur.fill ? fill_q : i_vram_dout;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      dir_q       <= 1'b0;
      lines_q     <= '0;
      fill_q      <= '0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_hold_q <= vram_addr;
      din_hold_q  <= vram_din;
      // Operands are captured once; later input changes cannot disturb a run.
      if (state_q == S_IDLE && i_start) begin
        dir_q   <= i_dir;
        lines_q <= i_lines;
        fill_q  <= i_fill;
      end
    end
  end

  assign o_busy      = (state_q == S_READ) || (state_q == S_WRITE);
  assign o_done      = (state_q == S_DONE);
  assign o_vram_ce   = o_busy;
  assign o_vram_wre  = (state_q == S_WRITE);
  assign o_vram_addr = vram_addr;
  assign o_vram_din  = vram_din;

endmodule

// File: tb/tb_vram_scroll.sv
// -----------------------------------------------------------------------------
// tb_vram_scroll
// Directed bench for vram_scroll: a behavioural VRAM with a preload pattern,
// activity counters, and hand-derived expected grids and cycle counts.
// -----------------------------------------------------------------------------
module tb_vram_scroll;

  localparam int ROW_W = 5;
  localparam int COL_W = 6;
  localparam int AW    = ROW_W + COL_W;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dir   = 1'b0;
  logic [4:0]    lines = '0;
  logic [7:0]    fill  = '0;
  logic          busy, done, ce, wre;
  logic [AW-1:0] addr;
  logic [7:0]    din;
  logic [7:0]    dout;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          preload_req = 1'b0;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, done_cnt = 0, oob_cnt = 0, stray_cnt = 0;
  int b_wr, b_rd, b_busy, b_done, b_oob, b_stray;

  always #5 clk = ~clk;

  vram_scroll #(
    .ROW_W(5), .COL_W(6), .LAST_ROW(16), .LAST_COL(59), .DATA_W(8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_dir       (dir),
    .i_lines     (lines),
    .i_fill      (fill),
    .o_busy      (busy),
    .o_done      (done),
    .o_vram_addr (addr),
    .o_vram_din  (din),
    .i_vram_dout (dout),
    .o_vram_ce   (ce),
    .o_vram_wre  (wre)
  );

  function automatic logic [7:0] pre(input int r, input int c);
    return 8'((r * 60 + c) % 256);
  endfunction

  // Synchronous VRAM model: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (preload_req) begin
      for (int r = 0; r <= 16; r++)
        for (int c = 0; c <= 59; c++)
          mem[r * 64 + c] <= pre(r, c);
    end else if (ce) begin
      if (wre) begin
        mem[addr] <= din;
        wr_cnt++;
      end else begin
        dout <= mem[addr];
      end
    end
  end

  // Activity counters sampled mid-cycle.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (ce && !wre) rd_cnt++;
    if (ce && !busy) stray_cnt++;
    if (ce && (addr[10:6] > 5'd16 || addr[5:0] > 6'd59)) oob_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // mode 0: up 1 / fill 0x20; 1: down 2 / fill 0x2E; 2: all 0x20
  function automatic int grid_errors(input int mode);
    int n = 0;
    logic [7:0] e;
    for (int r = 0; r <= 16; r++)
      for (int c = 0; c <= 59; c++) begin
        case (mode)
          0:       e = (r < 16) ? pre(r + 1, c) : 8'h20;
          1:       e = (r >= 2) ? pre(r - 2, c) : 8'h2E;
          default: e = 8'h20;
        endcase
        if (mem[r * 64 + c] !== e) n++;
      end
    return n;
  endfunction

  task automatic do_preload();
    @(negedge clk) preload_req = 1'b1;
    @(negedge clk) preload_req = 1'b0;
  endtask

  task automatic snap();
    #1;
    b_wr = wr_cnt; b_rd = rd_cnt; b_busy = busy_cnt;
    b_done = done_cnt; b_oob = oob_cnt; b_stray = stray_cnt;
  endtask

  task automatic start_op(input logic d, input logic [4:0] l, input logic [7:0] f);
    @(negedge clk);
    dir = d; lines = l; fill = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done_seen"}, 32'(done), 1);
    check({tag, " busy_at_done"}, 32'(busy), 0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int e_busy, input int e_rd, input int e_wr);
    check({tag, " busy_cycles"}, 32'(busy_cnt - b_busy), 32'(e_busy));
    check({tag, " reads"},       32'(rd_cnt - b_rd),     32'(e_rd));
    check({tag, " writes"},      32'(wr_cnt - b_wr),     32'(e_wr));
    check({tag, " done_pulses"}, 32'(done_cnt - b_done), 1);
    check({tag, " out_of_range"},32'(oob_cnt - b_oob),   0);
    check({tag, " ce_when_idle"},32'(stray_cnt - b_stray), 0);
  endtask

  initial begin
    int n;

    // 1: reset, then idle
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle busy", 32'(busy), 0);
    check("idle done", 32'(done), 0);
    check("idle ce",   32'(ce),   0);
    check("idle wre",  32'(wre),  0);
    check("idle addr", 32'(addr), 0);
    check("idle din",  32'(din),  0);
    rst_n = 1'b0;
    #1 check("reset in idle outputs", 32'({busy, done, ce, wre, addr, din}), 0);
    @(negedge clk) rst_n = 1'b1;

    // 2: up by one, fill with spaces
    do_preload();
    snap();
    start_op(1'b0, 5'd1, 8'h20);
    wait_done("up1");
    check_counts("up1", 1980, 960, 1020);
    check("up1 grid errors", 32'(grid_errors(0)), 0);
    check("up1 cell r0c0",   32'(mem[0]),         32'h3C);
    check("up1 cell r16c5",  32'(mem[16*64+5]),   32'h20);

    // 3: down by two, fill with dots
    do_preload();
    snap();
    start_op(1'b1, 5'd2, 8'h2E);
    wait_done("dn2");
    check_counts("dn2", 1920, 900, 1020);
    check("dn2 grid errors", 32'(grid_errors(1)), 0);
    check("dn2 cell r2c0",   32'(mem[2*64]),      32'h00);
    check("dn2 cell r1c59",  32'(mem[1*64+59]),   32'h2E);

    // 4a: zero lines; a start held into the DONE cycle is ignored
    snap();
    start_op(1'b0, 5'd0, 8'h20);
    @(negedge clk);
    check("zero done_now", 32'(done), 1);
    check("zero busy_now", 32'(busy), 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("zero done_pulses", 32'(done_cnt - b_done), 1);
    check("zero busy_cycles", 32'(busy_cnt - b_busy), 0);
    check("zero accesses",    32'((rd_cnt - b_rd) + (wr_cnt - b_wr)), 0);

    // 4b: more lines than the screen holds clears everything
    do_preload();
    snap();
    start_op(1'b0, 5'd20, 8'h20);
    wait_done("clr");
    check_counts("clr", 1020, 0, 1020);
    check("clr grid errors", 32'(grid_errors(2)), 0);

    // 5: restart attempt and input changes mid-run have no effect
    do_preload();
    snap();
    start_op(1'b0, 5'd1, 8'h20);
    repeat (100) @(negedge clk);
    start = 1'b1; dir = 1'b1; lines = 5'd5; fill = 8'h41;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("rst");
    check_counts("rst", 1980, 960, 1020);
    check("rst grid errors", 32'(grid_errors(0)), 0);

    // 6: reset mid-operation after 500 busy cycles (250 cells written)
    do_preload();
    snap();
    dir = 1'b0;
    start_op(1'b0, 5'd1, 8'h20);
    n = 0;
    while ((busy_cnt - b_busy) < 500 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort reached 500", 32'(busy_cnt - b_busy), 500);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort outputs drop", 32'({busy, done, ce, wre}), 0);
    repeat (5) @(negedge clk);
    check("abort writes", 32'(wr_cnt - b_wr), 250);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("abort writes after release", 32'(wr_cnt - b_wr), 250);
    check("abort done_pulses", 32'(done_cnt - b_done), 0);
    check("abort r3c59 copied",   32'(mem[3*64+59]), 32'(pre(4, 59)));
    check("abort r4c9 copied",    32'(mem[4*64+9]),  32'(pre(5, 9)));
    check("abort r4c10 untouched",32'(mem[4*64+10]), 32'(pre(4, 10)));
    check("abort r16c59 untouched",32'(mem[16*64+59]), 32'(pre(16, 59)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_scroll.md
Name: vram_scroll

Overview:
Parametrised VRAM scroll engine for the text-mode display path. It sits between the terminal controller and the text block's VRAM port. On a start pulse it moves the character grid up or down by a programmable number of lines and writes a programmable fill character into the vacated rows. A busy/done handshake is provided. It generalises the fixed one-line, scroll-up, zero-fill engine.

Parameters:
ROW_W, 5, width of the row field of the VRAM address.
COL_W, 6, width of the column field of the VRAM address.
LAST_ROW, 16, index of the last visible row (rows 0..LAST_ROW).
LAST_COL, 59, index of the last visible column (cols 0..LAST_COL).
DATA_W, 8, VRAM character width.

Ports:
i_clk  in  1  system clock (24 MHz).
i_rst_n  in  1  reset; asynchronous, active-low.
i_start  in  1  start request; sampled only in IDLE.
i_dir  in  1  0 = scroll up (content moves toward row 0), 1 = scroll down.
i_lines  in  ROW_W  number of lines to scroll.
i_fill  in  DATA_W  character written into vacated rows.
o_busy  out  1  high from the cycle after start is accepted until done.
o_done  out  1  one-cycle pulse when the operation completes.
o_vram_addr  out  ROW_W+COL_W  VRAM address, {row, col}.
o_vram_din  out  DATA_W  VRAM write data.
i_vram_dout  in  DATA_W  VRAM read data; valid one cycle after the address, when ce=1 and wre=0.
o_vram_ce  out  1  VRAM clock enable.
o_vram_wre  out  1  VRAM write enable (1 = write, 0 = read).

Behaviour:
- Reset (asynchronous assert, synchronous deassert at i_clk): state IDLE. All outputs are 0: o_busy, o_done, o_vram_ce, o_vram_wre, o_vram_addr, o_vram_din. Mid-operation reset aborts immediately; no further VRAM access occurs.
- States: IDLE, READ, WRITE, DONE.
- IDLE: when i_start=1, latch i_dir, i_lines and i_fill, then initialise the destination position. In up mode this is row 0, col 0. In down mode it is row LAST_ROW, col 0. If the latched lines value is 0, go to DONE with no VRAM access. Otherwise go to the first cell state, described below. i_start is ignored in every other state, and later changes to the inputs have no effect.
- Cell classification: the source row is computed with ROW_W+1 bits.
  - Up mode: src = dst + lines; the cell is a fill cell if src > LAST_ROW.
  - Down mode: the cell is a fill cell if dst < lines; otherwise src = dst - lines.
- Copy cell:
  - READ cycle: ce=1, wre=0, addr={src,col}.
  - Next cycle, WRITE: ce=1, wre=1, addr={dst,col}, din=i_vram_dout.
  - A copy cell takes 2 cycles.
- Fill cell: WRITE only, with ce=1, wre=1, addr={dst,col}, din=latched fill. A fill cell takes 1 cycle.
- After each WRITE the position advances:
  - col increments; at LAST_COL it wraps to 0 and the row advances.
  - In up mode the row increments; in down mode it decrements.
  - Row ordering guarantees a source is always read before it is overwritten.
- After the WRITE of the final cell (up: row LAST_ROW, col LAST_COL; down: row 0, col LAST_COL) the next state is DONE.
- DONE: o_done=1 and o_busy=0 for exactly one cycle, then IDLE. If i_start=1 in that DONE cycle it is ignored.
- o_busy=1 in READ and WRITE. ce=0 and wre=0 in IDLE and DONE. addr and din hold their last value when idle.
- lines > LAST_ROW: every cell is a fill cell, so the whole screen is cleared to the fill character.
- Total busy cycles for lines = k ≤ LAST_ROW+1: ((LAST_ROW+1−k)·2 + k)·(LAST_COL+1).
- No out-of-range address is ever driven. Row and col always satisfy row ≤ LAST_ROW and col ≤ LAST_COL.

Test Plan:
1. Reset then idle for 10 cycles -> all outputs 0; asserting i_rst_n low during IDLE keeps them 0.
2. VRAM cell(r,c)=r*60+c mod 256; start up, lines=1, fill=0x20 -> o_busy high for 16·120+60=1980 cycles, then o_done pulses once. Row r holds the old row r+1 for r<16; row 16 holds 0x20.
3. Same preload; start down, lines=2, fill=0x2E -> busy for 15·120+2·60=1920 cycles. Row r holds the old row r−2 for r≥2; rows 0–1 hold 0x2E.
4. lines=0 -> no ce activity, o_busy never high, o_done pulses on the second cycle after start. lines=20 -> 1020 writes, all 0x20, no reads.
5. Pulse i_start again at cycle 100 of a busy operation, and change i_lines/i_fill -> no effect; the result equals scenario 2 exactly.
6. Assert i_rst_n low at cycle 500 of scenario 2 -> ce, wre, busy and done drop asynchronously. There are no further writes, and cells not yet written keep their preload values.
